// File: rtl/aluPkg.sv
// Shared ALU definitions: the operation encoding used by the alu datapath and
// by every requester that talks to it through alu_arbiter.
package aluPkg;

   typedef enum logic [3:0] {
      OpAdd  = 4'd0,
      OpSub  = 4'd1,
      OpAnd  = 4'd2,
      OpOr   = 4'd3,
      OpXor  = 4'd4,
      OpSll  = 4'd5,
      OpSrl  = 4'd6,
      OpSra  = 4'd7,
      OpSlt  = 4'd8,
      OpSltu = 4'd9
   } alu_op;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU.
// Ports:
//   in1, in2 : operands (XLEN bits)
//   op       : operation select (aluPkg::alu_op)
//   out      : result (XLEN bits); shifts use the low log2(XLEN) bits of in2,
//              set-less-than ops return 0 or 1.
module alu #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   input  aluPkg::alu_op   op,
   output logic [XLEN-1:0] out
);

   localparam int unsigned ShW = $clog2(XLEN);

   logic [ShW-1:0] shamt;
   logic           lt_signed;
   logic           lt_unsigned;

   always_comb begin
      shamt       = in2[ShW-1:0];
      lt_signed   = $signed(in1) < $signed(in2);
      lt_unsigned = in1 < in2;
      out         = '0;
      case (op)
         aluPkg::OpAdd:  out = in1 + in2;
         aluPkg::OpSub:  out = in1 - in2;
         aluPkg::OpAnd:  out = in1 & in2;
         aluPkg::OpOr:   out = in1 | in2;
         aluPkg::OpXor:  out = in1 ^ in2;
         aluPkg::OpSll:  out = in1 << shamt;
         aluPkg::OpSrl:  out = in1 >> shamt;
         aluPkg::OpSra:  out = $unsigned($signed(in1) >>> shamt);
         aluPkg::OpSlt:  out = {{(XLEN-1){1'b0}}, lt_signed};
         aluPkg::OpSltu: out = {{(XLEN-1){1'b0}}, lt_unsigned};
         default:        out = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu between two requesters. Each port has a
// valid/ready request channel and a one-entry response buffer, so a result
// appears one cycle after acceptance and is held until the requester takes it.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   reqN_valid/ready     : request handshake for port N (0 or 1)
//   reqN_in1/in2/op      : request operands and operation
//   rspN_valid/ready     : response handshake for port N
//   rspN_data            : buffered result for port N
//   busy                 : either response buffer holds an unconsumed result
module alu_arbiter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [XLEN-1:0] req0_in1,
   input  logic [XLEN-1:0] req0_in2,
   input  aluPkg::alu_op   req0_op,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic [XLEN-1:0] rsp0_data,

   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [XLEN-1:0] req1_in1,
   input  logic [XLEN-1:0] req1_in2,
   input  aluPkg::alu_op   req1_op,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [XLEN-1:0] rsp1_data,

   output logic            busy
);

   logic            elig0;
   logic            elig1;
   logic            grant0;
   logic            grant1;
   logic            ptr_q;  // 0: port 0 wins a tie, 1: port 1 wins a tie
   logic            rsp0_valid_q;
   logic            rsp1_valid_q;
   logic [XLEN-1:0] rsp0_data_q;
   logic [XLEN-1:0] rsp1_data_q;
   logic [XLEN-1:0] alu_in1;
   logic [XLEN-1:0] alu_in2;
   logic [XLEN-1:0] alu_out;
   aluPkg::alu_op   alu_op_sel;

   // A full buffer that is being drained this cycle counts as free.
   always_comb begin
      elig0  = ~rst & req0_valid & (~rsp0_valid_q | rsp0_ready);
      elig1  = ~rst & req1_valid & (~rsp1_valid_q | rsp1_ready);
      grant0 = elig0 & (~elig1 | ~ptr_q);
      grant1 = elig1 & (~elig0 | ptr_q);
   end

   // Idle ALU inputs are parked at a constant so the datapath stays quiet.
   always_comb begin
      alu_in1    = '0;
      alu_in2    = '0;
      alu_op_sel = aluPkg::OpAdd;
      if (grant0) begin
         alu_in1    = req0_in1;
         alu_in2    = req0_in2;
         alu_op_sel = req0_op;
      end else if (grant1) begin
         alu_in1    = req1_in1;
         alu_in2    = req1_in2;
         alu_op_sel = req1_op;
      end
   end

   alu #(
      .XLEN(XLEN)
   ) u_alu (
      .in1(alu_in1),
      .in2(alu_in2),
      .op (alu_op_sel),
      .out(alu_out)
   );

   // A new grant takes precedence over a drain so the buffer refills in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
         ptr_q        <= 1'b0;
      end else begin
         if (grant0) begin
            rsp0_valid_q <= 1'b1;
            rsp0_data_q  <= alu_out;
         end else if (rsp0_ready) begin
            rsp0_valid_q <= 1'b0;
         end

         if (grant1) begin
            rsp1_valid_q <= 1'b1;
            rsp1_data_q  <= alu_out;
         end else if (rsp1_ready) begin
            rsp1_valid_q <= 1'b0;
         end

         if (grant0) begin
            ptr_q <= 1'b1;
         end else if (grant1) begin
            ptr_q <= 1'b0;
         end
      end
   end

   always_comb begin
      req0_ready = grant0;
      req1_ready = grant1;
      rsp0_valid = rsp0_valid_q;
      rsp1_valid = rsp1_valid_q;
      rsp0_data  = rsp0_data_q;
      rsp1_data  = rsp1_data_q;
      busy       = rsp0_valid_q | rsp1_valid_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a cycle-by-cycle vector table covering
// reset, streaming, contention, backpressure and drain/refill, followed by an
// op sweep on port 1 checked against a reference ALU.
module tb_alu_arbiter;
   import aluPkg::*;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            rst;
   logic            req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic            req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [XLEN-1:0] req0_in1, req0_in2, rsp0_data;
   logic [XLEN-1:0] req1_in1, req1_in2, rsp1_data;
   alu_op           req0_op, req1_op;
   logic            busy;

   int total;
   int bad;

   typedef struct {
      logic        rst;
      logic        v0;
      logic [31:0] a0;
      logic [31:0] b0;
      alu_op       op0;
      logic        r0;
      logic        v1;
      logic [31:0] a1;
      logic [31:0] b1;
      alu_op       op1;
      logic        r1;
      logic        er0;   // expected req0_ready before the edge
      logic        er1;
      logic        ev0;   // expected registered outputs after the edge
      logic [31:0] ed0;
      logic        ev1;
      logic [31:0] ed1;
   } vec_t;

   vec_t vecs[$];

   alu_arbiter #(
      .XLEN(XLEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_in1  (req0_in1),
      .req0_in2  (req0_in2),
      .req0_op   (req0_op),
      .rsp0_valid(rsp0_valid),
      .rsp0_ready(rsp0_ready),
      .rsp0_data (rsp0_data),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_in1  (req1_in1),
      .req1_in2  (req1_in2),
      .req1_op   (req1_op),
      .rsp1_valid(rsp1_valid),
      .rsp1_ready(rsp1_ready),
      .rsp1_data (rsp1_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input alu_op op);
      logic [31:0] r;
      r = 32'h0;
      case (op)
         OpAdd:  r = a + b;
         OpSub:  r = a + (~b) + 32'd1;
         OpAnd:  r = a & b;
         OpOr:   r = a | b;
         OpXor:  r = a ^ b;
         OpSll:  r = a << b[4:0];
         OpSrl:  r = a >> b[4:0];
         OpSra:  r = (a >> b[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'h0);
         OpSlt:  r = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, a < b};
         OpSltu: r = {31'h0, a < b};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s idx=%0d got=%h want=%h", name, idx, act, exp);
      end
   endtask

   task automatic add_vec(input logic rs,
                          input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                          input alu_op op0, input logic r0,
                          input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                          input alu_op op1, input logic r1,
                          input logic er0, input logic er1,
                          input logic ev0, input logic [31:0] ed0,
                          input logic ev1, input logic [31:0] ed1);
      vec_t v;
      v.rst = rs;
      v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0; v.r0 = r0;
      v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1; v.r1 = r1;
      v.er0 = er0; v.er1 = er1;
      v.ev0 = ev0; v.ed0 = ed0; v.ev1 = ev1; v.ed1 = ed1;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      rst        = v.rst;
      req0_valid = v.v0; req0_in1 = v.a0; req0_in2 = v.b0; req0_op = v.op0;
      rsp0_ready = v.r0;
      req1_valid = v.v1; req1_in1 = v.a1; req1_in2 = v.b1; req1_op = v.op1;
      rsp1_ready = v.r1;
   endtask

   localparam logic [31:0] N4  = 32'hFFFF_FFFC;  // -4
   localparam logic [31:0] N16 = 32'hFFFF_FFF0;  // -16
   localparam logic [31:0] F9  = 32'hFFFF_FFF9;  // 3 - 10
   localparam logic [31:0] F2  = 32'hFFFF_FFF2;  // -16 + 2

   initial begin
      vec_t v;
      logic [31:0] pa[5];
      logic [31:0] pb[5];
      alu_op op;
      int n;
      total = 0;
      bad   = 0;

      // rst v0 a0 b0 op0 r0 | v1 a1 b1 op1 r1 | er0 er1 | ev0 ed0 ev1 ed1
      // 0: reset
      add_vec(1, 0, 0, 0, OpAdd, 0, 0, 0, 0, OpAdd, 0, 0, 0, 0, 0, 0, 0);
      // 1-4: port 0 streaming, then idle drain
      add_vec(0, 1, 10, 2, OpAdd, 1, 0, 0, 0, OpAdd, 0, 1, 0, 1, 12, 0, 0);
      add_vec(0, 1, 3, 10, OpAdd, 1, 0, 0, 0, OpAdd, 0, 1, 0, 1, 13, 0, 0);
      add_vec(0, 1, N4, 4, OpAdd, 1, 0, 0, 0, OpAdd, 0, 1, 0, 1, 0, 0, 0);
      add_vec(0, 0, 0, 0, OpAdd, 1, 0, 0, 0, OpAdd, 0, 0, 0, 0, 0, 0, 0);
      // 5-9: contention; pointer was left at port 1 by the last port 0 grant
      add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpSub, 1, 0, 1, 0, 0, 1, F9);
      add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpSub, 1, 1, 0, 1, 12, 0, F9);
      add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpSub, 1, 0, 1, 0, 12, 1, F9);
      add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpSub, 1, 1, 0, 1, 12, 0, F9);
      add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpSub, 1, 0, 1, 0, 12, 1, F9);
      // 10-14: port 1 backpressured for 4 cycles, then refilled on release
      for (int i = 0; i < 4; i++) begin
         add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpAdd, 0, 1, 0, 1, 12, 1, F9);
      end
      add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpAdd, 1, 0, 1, 0, 12, 1, 13);
      // 15-17: port 0 drain-and-refill, then drain only
      add_vec(0, 1, 10, 2, OpAdd, 1, 0, 0, 0, OpAdd, 1, 1, 0, 1, 12, 0, 13);
      add_vec(0, 1, N16, 2, OpAdd, 1, 0, 0, 0, OpAdd, 1, 1, 0, 1, F2, 0, 13);
      add_vec(0, 0, 0, 0, OpAdd, 1, 0, 0, 0, OpAdd, 1, 0, 0, 0, F2, 0, 13);
      // 18-22: reset mid-traffic, then post-reset contention starts at port 0
      add_vec(0, 1, 10, 2, OpAdd, 0, 0, 0, 0, OpAdd, 0, 1, 0, 1, 12, 0, 13);
      add_vec(0, 0, 0, 0, OpAdd, 0, 0, 0, 0, OpAdd, 0, 0, 0, 1, 12, 0, 13);
      add_vec(1, 0, 0, 0, OpAdd, 0, 1, 3, 10, OpSub, 0, 0, 0, 0, 0, 0, 0);
      add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpSub, 1, 1, 0, 1, 12, 0, 0);
      add_vec(0, 1, 10, 2, OpAdd, 1, 1, 3, 10, OpSub, 1, 0, 1, 0, 12, 1, F9);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         drive(v);
         #1;
         chk("req0_ready", i, {31'h0, req0_ready}, {31'h0, v.er0});
         chk("req1_ready", i, {31'h0, req1_ready}, {31'h0, v.er1});
         @(posedge clk);
         #1;
         chk("rsp0_valid", i, {31'h0, rsp0_valid}, {31'h0, v.ev0});
         chk("rsp0_data", i, rsp0_data, v.ed0);
         chk("rsp1_valid", i, {31'h0, rsp1_valid}, {31'h0, v.ev1});
         chk("rsp1_data", i, rsp1_data, v.ed1);
         chk("busy", i, {31'h0, busy}, {31'h0, v.ev0 | v.ev1});
      end

      // Op sweep on port 1 with its response always consumed.
      pa[0] = 10;  pb[0] = 2;
      pa[1] = 3;   pb[1] = 10;
      pa[2] = N4;  pb[2] = 4;
      pa[3] = 4;   pb[3] = N4;
      pa[4] = N16; pb[4] = 2;
      n = 0;
      @(negedge clk);
      rst = 0; req0_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
      for (int p = 0; p < 5; p++) begin
         op = op.first();
         do begin
            @(negedge clk);
            req1_valid = 1; req1_in1 = pa[p]; req1_in2 = pb[p]; req1_op = op;
            #1;
            chk("sweep_ready", n, {31'h0, req1_ready}, 32'h1);
            @(posedge clk);
            #1;
            chk("sweep_valid", n, {31'h0, rsp1_valid}, 32'h1);
            chk("sweep_data", n, rsp1_data, ref_alu(pa[p], pb[p], op));
            n++;
            op = op.next();
         end while (op != op.first());
      end
      @(negedge clk);
      req1_valid = 0;
      @(posedge clk);
      #1;
      chk("sweep_drain", n, {31'h0, rsp1_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters (port 0, port 1), for example the execute stage and a multi-cycle helper unit.
- Each port has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Each port has a one-entry response buffer, so results are returned one cycle after acceptance and held until the requester takes them.

Parameters:
- XLEN, 32, operand and result width; must equal the `alu` datapath width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when high with req0_valid
- req0_in1  in  XLEN  port 0 operand 1
- req0_in2  in  XLEN  port 0 operand 2
- req0_op  in  aluPkg::alu_op  port 0 operation
- rsp0_valid  out  1  port 0 result valid
- rsp0_ready  in  1  port 0 consumes result
- rsp0_data  out  XLEN  port 0 result
- req1_valid, req1_ready, req1_in1, req1_in2, req1_op, rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for port 1
- busy  out  1  high when either response buffer holds an unconsumed result

Behaviour:
- Reset (rst=1 at an edge):
  - rsp0_valid=0, rsp1_valid=0, rsp0_data=0, rsp1_data=0.
  - Priority pointer = port 0.
  - busy=0.
  - Overrides any in-flight transfer. A request presented in the reset cycle is not accepted; req*_ready=0 while rst=1.
- Eligibility: port p is eligible when reqp_valid=1 AND (rspp_valid=0 OR rspp_ready=1). A full buffer being drained in the same cycle counts as free.
- Grant (combinational, at most one per cycle):
  - Only one port eligible: that port is granted.
  - Both eligible: the port named by the priority pointer is granted.
  - None eligible: no grant.
- reqp_ready = grant to port p. It depends combinationally on reqp_valid, rspp_valid, rspp_ready and the pointer.
- The ALU is driven by the granted port's in1/in2/op. With no grant, ALU inputs are held at 0 / op.first (don't-care, but stable).
- Acceptance at edge t:
  - rspp_data <= alu_out, rspp_valid <= 1.
  - Visible at cycle t+1, so latency is 1 cycle request-to-response.
- Response hold: rspp_valid and rspp_data are stable until an edge with rspp_ready=1, after which rspp_valid <= 0 unless a new grant to p occurs in the same cycle. A new grant wins: valid stays 1 with the new data.
- Pointer update:
  - After any grant to port p, the pointer moves to the other port.
  - No grant: pointer unchanged.
  - Result: strict alternation under continuous contention; a lone requester is granted every cycle.
- Throughput: one accepted request per cycle total. A single port with rspp_ready tied high achieves one result per cycle.
- Arithmetic: results are exactly the `alu` output for (in1, in2, op). The arbiter does no width extension or modification.
- busy = rsp0_valid | rsp1_valid (registered state only).
- Requesters must hold reqp_* stable while reqp_valid=1 and reqp_ready=0. The arbiter does not check this.
- rspp_ready while rspp_valid=0 is ignored.

Test Plan:
- Reset mid-traffic: rsp0_valid=1 holding 12, assert rst one cycle with req1_valid=1 → next cycle rsp0_valid=0, rsp1_valid=0, busy=0, req1 not accepted during rst; first post-reset contention grants port 0.
- Single port streaming: port 0 issues ADD (10,2), (3,10), (-4,4) back-to-back, rsp0_ready=1 → req0_ready=1 every cycle; rsp0_data = 12, 13, 0 on consecutive cycles starting one cycle after the first acceptance.
- Contention alternation: both ports valid continuously with rsp*_ready=1, port 0 ADD(10,2), port 1 SUB(3,10) → grants 0,1,0,1…; rsp0_data=12, rsp1_data=0xFFFFFFF9 on alternate cycles.
- Backpressure: port 1 result 0xFFFFFFF9 held, rsp1_ready=0 for 4 cycles, req1_valid=1 → req1_ready=0 for those cycles, rsp1_data stable; port 0 still granted each cycle; on rsp1_ready=1, req1 accepted in the same cycle and the new result appears next cycle with rsp1_valid staying 1.
- Drain-and-refill: rsp0_valid=1, rsp0_ready=1 and req0_valid=1 in the same cycle → req0_ready=1; next cycle rsp0_valid=1 with the new result. With req0_valid=0 instead → rsp0_valid=0 next cycle.
- Op sweep: for each operand pair (10,2), (3,10), (-4,4), (4,-4), (-16,2), iterate every aluPkg::alu_op from op.first through op.next back to first on port 1 → each rsp1_data matches a reference model of `alu` for that op.
